// File: rtl/contador_checker.sv
// Sequence monitor for the 8-bit up/down counter: predicts each next q, counts passes/fails/wraps
// and captures the first mismatch. Define CHK_HOLD_EN to add the 'hold' input (counter stalled).
module contador_checker #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sync_req,
`ifdef CHK_HOLD_EN
   input  logic             hold,
`endif
   input  logic [WIDTH-1:0] q,
   input  logic             mode,
   output logic             locked,
   output logic             err_pulse,
   output logic             wrap_pulse,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] wrap_cnt,
   output logic [WIDTH-1:0] exp_q,
   output logic [WIDTH-1:0] first_act,
   output logic [WIDTH-1:0] first_exp,
   output logic             first_vld
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEED  = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] v, input logic m);
      return m ? (v - ONE_V) : (v + ONE_V);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : (c + CNT_ONE);
   endfunction

   state_t           state_r, state_s;
   logic [WIDTH-1:0] prev_q_r;
   logic             prev_mode_r;
   logic             upd_s, cmp_s, hold_s, match_s, err_s, pass_s, wrap_s;
   logic [WIDTH-1:0] cmp_exp_s;

`ifdef CHK_HOLD_EN
   assign hold_s = hold;
`else
   assign hold_s = 1'b0;
`endif

   // A stalled counter must repeat its last sample instead of stepping
   assign cmp_exp_s = hold_s ? prev_q_r : exp_q;
   assign match_s   = (q == cmp_exp_s);
   assign err_s     = cmp_s & ~match_s;
   assign pass_s    = cmp_s & match_s;
   assign wrap_s    = pass_s & ~hold_s & (mode ? (q == MAX_V) : (q == ZERO_V));

   // Next-state and per-cycle decision: en=0 > sync_req > direction change > compare
   always_comb begin
      state_s = state_r;
      upd_s   = 1'b0;
      cmp_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (en) state_s = SEED;
            else    state_s = IDLE;
         end
         SEED: begin
            if (!en) begin
               state_s = IDLE;
            end else begin
               state_s = CHECK;
               upd_s   = 1'b1;
            end
         end
         CHECK: begin
            if (!en) begin
               state_s = IDLE;
            end else begin
               state_s = CHECK;
               upd_s   = 1'b1;
               if (sync_req)                 cmp_s = 1'b0;
               else if (mode != prev_mode_r) cmp_s = 1'b0;
               else                          cmp_s = 1'b1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, prediction and pulse registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         locked      <= 1'b0;
         err_pulse   <= 1'b0;
         wrap_pulse  <= 1'b0;
         prev_q_r    <= ZERO_V;
         prev_mode_r <= 1'b0;
         exp_q       <= ZERO_V;
      end else begin
         state_r    <= state_s;
         locked     <= (state_s == CHECK);
         err_pulse  <= err_s;
         wrap_pulse <= wrap_s;
         if (upd_s) begin
            prev_q_r    <= q;
            prev_mode_r <= mode;
            exp_q       <= next_val(q, mode);
         end else begin
            prev_q_r    <= prev_q_r;
            prev_mode_r <= prev_mode_r;
            exp_q       <= exp_q;
         end
      end
   end

   // Saturating statistics and first-failure capture (cleared only by reset)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pass_cnt  <= {CNT_W{1'b0}};
         fail_cnt  <= {CNT_W{1'b0}};
         wrap_cnt  <= {CNT_W{1'b0}};
         first_act <= ZERO_V;
         first_exp <= ZERO_V;
         first_vld <= 1'b0;
      end else begin
         if (pass_s) pass_cnt <= sat_inc(pass_cnt);
         else        pass_cnt <= pass_cnt;
         if (err_s)  fail_cnt <= sat_inc(fail_cnt);
         else        fail_cnt <= fail_cnt;
         if (wrap_s) wrap_cnt <= sat_inc(wrap_cnt);
         else        wrap_cnt <= wrap_cnt;
         if (err_s && !first_vld) begin
            first_act <= q;
            first_exp <= cmp_exp_s;
            first_vld <= 1'b1;
         end else begin
            first_act <= first_act;
            first_exp <= first_exp;
            first_vld <= first_vld;
         end
      end
   end

endmodule
